// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU codes, flag bit positions and default widths for the 16-bit pipeline
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;
  localparam int CPU_FUNC_W = 2;

  localparam logic [CPU_FUNC_W-1:0] ALU_ADD = 2'b00;
  localparam logic [CPU_FUNC_W-1:0] ALU_SUB = 2'b01;
  localparam logic [CPU_FUNC_W-1:0] ALU_AND = 2'b10;
  localparam logic [CPU_FUNC_W-1:0] ALU_OR  = 2'b11;

  // flagsM is packed {V,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU (ADD/SUB/AND/OR) producing result and {V,C,Z} flags
module exec_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int FUNC_W = CPU_FUNC_W
)(
  input  logic [FUNC_W-1:0] aluFunc,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            ovf;

  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (aluFunc)
      ALU_ADD: begin
        sum = {1'b0, srcA} + {1'b0, srcB};
        ovf = (srcA[MSB] == srcB[MSB]) && (sum[MSB] != srcA[MSB]);
      end
      ALU_SUB: begin
        // carry out of A + ~B + 1 is set when no borrow occurs
        sum = {1'b0, srcA} + {1'b0, ~srcB} + {{DATA_W{1'b0}}, 1'b1};
        ovf = (srcA[MSB] != srcB[MSB]) && (sum[MSB] != srcA[MSB]);
      end
      ALU_AND: sum = {1'b0, srcA & srcB};
      default: sum = {1'b0, srcA | srcB};
    endcase
  end

  always_comb begin
    result        = sum[DATA_W-1:0];
    flags         = '0;
    flags[FLAG_Z] = (sum[DATA_W-1:0] == '0);
    flags[FLAG_C] = sum[DATA_W];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/execute_mem_stage.sv
// rtl/execute_mem_stage.sv - execute stage with EX/MEM register, skid buffer and retired-op counter
// Optional operand forwarding is enabled by defining EXEC_FWD_EN.
module execute_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int FUNC_W = CPU_FUNC_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemToRegE,
  input  logic [FUNC_W-1:0] aluFuncE,
  input  logic [DATA_W-1:0] srcDataE1,
  input  logic [DATA_W-1:0] srcDataE2,
  input  logic [ADDR_W-1:0] destAddE,
`ifdef EXEC_FWD_EN
  input  logic [ADDR_W-1:0] srcAddE1,
  input  logic [ADDR_W-1:0] srcAddE2,
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbDestAdd,
  input  logic [DATA_W-1:0] wbData,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemToRegM,
  output logic [DATA_W-1:0] aluResultM,
  output logic [DATA_W-1:0] writeDataM,
  output logic [ADDR_W-1:0] destAddM,
  output logic [2:0]        flagsM,
  output logic [15:0]       retiredCnt
);

  typedef struct packed {
    logic              regWrite;
    logic              memWrite;
    logic              memToReg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] destAdd;
    logic [2:0]        flags;
  } exOp_t;

  exOp_t outOp, skidOp, newOp;
  logic  outValid, skidValid, skidValidNext, inReadyQ;
  logic  accept, drain;
  logic [DATA_W-1:0] opA, opB, aluResult;
  logic [2:0]        aluFlags;

`ifdef EXEC_FWD_EN
  // the EX/MEM result is only forwardable when it is a register write that does not come from memory
  logic exFwdOk;
  assign exFwdOk = outValid & outOp.regWrite & ~outOp.memToReg;
  assign opA = (exFwdOk && outOp.destAdd == srcAddE1) ? outOp.aluResult :
               (wbRegWrite && wbDestAdd == srcAddE1)  ? wbData : srcDataE1;
  assign opB = (exFwdOk && outOp.destAdd == srcAddE2) ? outOp.aluResult :
               (wbRegWrite && wbDestAdd == srcAddE2)  ? wbData : srcDataE2;
`else
  assign opA = srcDataE1;
  assign opB = srcDataE2;
`endif

  exec_alu #(.DATA_W(DATA_W), .FUNC_W(FUNC_W)) u_alu (
    .aluFunc (aluFuncE),
    .srcA    (opA),
    .srcB    (opB),
    .result  (aluResult),
    .flags   (aluFlags)
  );

  always_comb begin
    newOp.regWrite  = RegWriteE;
    newOp.memWrite  = MemWriteE;
    newOp.memToReg  = MemToRegE;
    newOp.aluResult = aluResult;
    newOp.writeData = opB;
    newOp.destAdd   = destAddE;
    newOp.flags     = aluFlags;
  end

  assign accept = in_valid & inReadyQ;
  assign drain  = outValid & out_ready;

  // in_ready is registered from the next skid state, so accept and skid-to-output load never overlap
  always_comb begin
    skidValidNext = skidValid;
    if (flush)
      skidValidNext = 1'b0;
    else if (!outValid || drain)
      skidValidNext = 1'b0;
    else if (accept)
      skidValidNext = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outOp      <= '0;
      skidOp     <= '0;
      outValid   <= 1'b0;
      skidValid  <= 1'b0;
      inReadyQ   <= 1'b1;
      retiredCnt <= '0;
    end else begin
      if (drain)
        retiredCnt <= retiredCnt + 16'd1;
      skidValid <= skidValidNext;
      inReadyQ  <= ~skidValidNext;
      if (flush) begin
        outValid <= 1'b0;
      end else if (!outValid || drain) begin
        if (skidValid) begin
          outOp    <= skidOp;
          outValid <= 1'b1;
        end else if (accept) begin
          outOp    <= newOp;
          outValid <= 1'b1;
        end else begin
          outValid <= 1'b0;
        end
      end else if (accept) begin
        skidOp <= newOp;
      end
    end
  end

  assign in_ready   = inReadyQ;
  assign out_valid  = outValid;
  assign RegWriteM  = outValid & outOp.regWrite;
  assign MemWriteM  = outValid & outOp.memWrite;
  assign MemToRegM  = outValid & outOp.memToReg;
  assign aluResultM = outOp.aluResult;
  assign writeDataM = outOp.writeData;
  assign destAddM   = outOp.destAdd;
  assign flagsM     = outOp.flags;

endmodule

// File: tb/tb_execute_mem_stage.sv
// tb/tb_execute_mem_stage.sv - directed self-checking bench for execute_mem_stage
module tb_execute_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush;
  logic        RegWriteE, MemWriteE, MemToRegE;
  logic [1:0]  aluFuncE;
  logic [15:0] srcDataE1, srcDataE2;
  logic [3:0]  destAddE;
`ifdef EXEC_FWD_EN
  logic [3:0]  srcAddE1, srcAddE2, wbDestAdd;
  logic        wbRegWrite;
  logic [15:0] wbData;
`endif
  logic        out_valid, out_ready;
  logic        RegWriteM, MemWriteM, MemToRegM;
  logic [15:0] aluResultM, writeDataM;
  logic [3:0]  destAddM;
  logic [2:0]  flagsM;
  logic [15:0] retiredCnt;

  int errCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  execute_mem_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .MemToRegE  (MemToRegE),
    .aluFuncE   (aluFuncE),
    .srcDataE1  (srcDataE1),
    .srcDataE2  (srcDataE2),
    .destAddE   (destAddE),
`ifdef EXEC_FWD_EN
    .srcAddE1   (srcAddE1),
    .srcAddE2   (srcAddE2),
    .wbRegWrite (wbRegWrite),
    .wbDestAdd  (wbDestAdd),
    .wbData     (wbData),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemToRegM  (MemToRegM),
    .aluResultM (aluResultM),
    .writeDataM (writeDataM),
    .destAddM   (destAddM),
    .flagsM     (flagsM),
    .retiredCnt (retiredCnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issueOp(input logic [1:0] func, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst, input logic rw, input logic mw, input logic mtr);
    aluFuncE  = func;
    srcDataE1 = a;
    srcDataE2 = b;
    destAddE  = dst;
    RegWriteE = rw;
    MemWriteE = mw;
    MemToRegE = mtr;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  logic [15:0] drained [4];
  int          nDrained;
  logic        willAccept;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    RegWriteE = 1'b0; MemWriteE = 1'b0; MemToRegE = 1'b0;
    aluFuncE = 2'b00; srcDataE1 = '0; srcDataE2 = '0; destAddE = '0;
`ifdef EXEC_FWD_EN
    srcAddE1 = 4'd14; srcAddE2 = 4'd14; wbRegWrite = 1'b0; wbDestAdd = '0; wbData = '0;
`endif
    repeat (2) @(posedge clk); #1;
    checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("rst_retired", {16'd0, retiredCnt}, 32'd0);
    checkVal("rst_result", {16'd0, aluResultM}, 32'd0);
    checkVal("rst_flags", {29'd0, flagsM}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD overflow, latency 1
    issueOp(2'b00, 16'h7FFF, 16'h0001, 4'd3, 1'b1, 1'b0, 1'b0);
    checkVal("add_valid", {31'd0, out_valid}, 32'd1);
    checkVal("add_result", {16'd0, aluResultM}, 32'h8000);
    checkVal("add_flags", {29'd0, flagsM}, 32'b100);
    checkVal("add_regwrite", {31'd0, RegWriteM}, 32'd1);
    checkVal("add_dest", {28'd0, destAddM}, 32'd3);
    @(posedge clk); #1;
    checkVal("add_retired", {16'd0, retiredCnt}, 32'd1);
    checkVal("add_drained", {31'd0, out_valid}, 32'd0);

    // SUB, AND, OR, ADD carry back-to-back
    issueOp(2'b01, 16'h0005, 16'h0005, 4'd1, 1'b1, 1'b0, 1'b0);
    checkVal("sub_eq_result", {16'd0, aluResultM}, 32'h0000);
    checkVal("sub_eq_flags", {29'd0, flagsM}, 32'b011);
    issueOp(2'b01, 16'h0000, 16'h0001, 4'd2, 1'b0, 1'b1, 1'b0);
    checkVal("sub_brw_result", {16'd0, aluResultM}, 32'hFFFF);
    checkVal("sub_brw_flags", {29'd0, flagsM}, 32'b000);
    checkVal("sub_brw_memwrite", {31'd0, MemWriteM}, 32'd1);
    checkVal("sub_brw_wdata", {16'd0, writeDataM}, 32'h0001);
    issueOp(2'b10, 16'hF0F0, 16'h0FF0, 4'd4, 1'b1, 1'b0, 1'b1);
    checkVal("and_result", {16'd0, aluResultM}, 32'h00F0);
    checkVal("and_flags", {29'd0, flagsM}, 32'b000);
    checkVal("and_memtoreg", {31'd0, MemToRegM}, 32'd1);
    issueOp(2'b11, 16'h0000, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0);
    checkVal("or_result", {16'd0, aluResultM}, 32'h0000);
    checkVal("or_flags", {29'd0, flagsM}, 32'b001);
    issueOp(2'b00, 16'hFFFF, 16'h0001, 4'd6, 1'b1, 1'b0, 1'b0);
    checkVal("addc_result", {16'd0, aluResultM}, 32'h0000);
    checkVal("addc_flags", {29'd0, flagsM}, 32'b011);
    @(posedge clk); #1;
    checkVal("seq_retired", {16'd0, retiredCnt}, 32'd6);

    // stall with skid full, then drain in order
    out_ready = 1'b0;
    issueOp(2'b00, 16'd1, 16'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    issueOp(2'b00, 16'd2, 16'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    aluFuncE = 2'b00; srcDataE1 = 16'd3; srcDataE2 = 16'd0; destAddE = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    checkVal("stall_valid", {31'd0, out_valid}, 32'd1);
    checkVal("stall_hold", {16'd0, aluResultM}, 32'd1);
    checkVal("stall_dest", {28'd0, destAddM}, 32'd1);
    checkVal("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    nDrained = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      willAccept = in_valid && in_ready;
      if (out_valid && out_ready && nDrained < 4) begin
        drained[nDrained] = aluResultM;
        nDrained++;
      end
      @(posedge clk); #1;
      if (willAccept) in_valid = 1'b0;
    end
    checkVal("drain_count", nDrained, 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < nDrained) checkVal($sformatf("drain_order%0d", i), {16'd0, drained[i]}, i + 1);
    checkVal("drain_retired", {16'd0, retiredCnt}, 32'd9);

    // flush with skid full
    out_ready = 1'b0;
    issueOp(2'b00, 16'd4, 16'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    issueOp(2'b00, 16'd5, 16'd0, 4'd5, 1'b1, 1'b1, 1'b0);
    checkVal("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkVal("flush_valid", {31'd0, out_valid}, 32'd0);
    checkVal("flush_regwrite", {31'd0, RegWriteM}, 32'd0);
    checkVal("flush_memwrite", {31'd0, MemWriteM}, 32'd0);
    checkVal("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("flush_retired", {16'd0, retiredCnt}, 32'd9);
    @(posedge clk); #1;
    checkVal("flush_skid_gone", {31'd0, out_valid}, 32'd0);

    // flush with same-cycle drain and same-cycle accept
    out_ready = 1'b1;
    issueOp(2'b00, 16'd6, 16'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkVal("flushd_valid", {31'd0, out_valid}, 32'd0);
    checkVal("flushd_retired", {16'd0, retiredCnt}, 32'd10);

    // asynchronous reset mid-stall
    out_ready = 1'b0;
    issueOp(2'b00, 16'd7, 16'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    issueOp(2'b00, 16'd8, 16'd0, 4'd8, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkVal("arst_valid", {31'd0, out_valid}, 32'd0);
    checkVal("arst_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("arst_result", {16'd0, aluResultM}, 32'd0);
    checkVal("arst_memwrite", {31'd0, MemWriteM}, 32'd0);
    checkVal("arst_retired", {16'd0, retiredCnt}, 32'd0);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    issueOp(2'b00, 16'h1234, 16'h1111, 4'd9, 1'b1, 1'b0, 1'b0);
    checkVal("post_rst_valid", {31'd0, out_valid}, 32'd1);
    checkVal("post_rst_result", {16'd0, aluResultM}, 32'h2345);
    @(posedge clk); #1;
    checkVal("post_rst_retired", {16'd0, retiredCnt}, 32'd1);

`ifdef EXEC_FWD_EN
    srcAddE1 = 4'd5; srcAddE2 = 4'd6;
    issueOp(2'b00, 16'd2, 16'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    checkVal("fwd_r1", {16'd0, aluResultM}, 32'h0005);
    srcAddE1 = 4'd1; srcAddE2 = 4'd1;
    issueOp(2'b00, 16'd0, 16'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    checkVal("fwd_ex", {16'd0, aluResultM}, 32'h000A);
    @(posedge clk); #1;
    wbRegWrite = 1'b1; wbDestAdd = 4'd1; wbData = 16'd7;
    issueOp(2'b00, 16'd0, 16'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    checkVal("fwd_wb", {16'd0, aluResultM}, 32'h000E);
    wbRegWrite = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
